// File: rtl/lsu_bus_initiator.sv
// Single-outstanding load/store initiator: checks alignment and range, drives a req/ack memory
// bus with an ack timeout, and returns a one-cycle registered response pulse.
module lsu_bus_initiator #(
    parameter int unsigned ADDR_LIMIT     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    // The edge that would take the counter to TIMEOUT_CYCLES is the abort edge.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StInit, StIdle, StBus, StResp} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            addr_bad;

    always_comb begin
        addr_bad = (core_addr[1:0] != 2'b00) || (core_addr >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StInit;
            cnt        <= '0;
            core_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            case (state)
                StInit: begin
                    state      <= StIdle;
                    core_ready <= 1'b1;
                end
                StIdle: begin
                    if (core_valid) begin
                        core_ready <= 1'b0;
                        if (addr_bad) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= StBus;
                            cnt       <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= core_write;
                            bus_addr  <= {core_addr[31:2], 2'b00};
                            bus_wdata <= core_wdata;
                        end
                    end
                end
                StBus: begin
                    // Ack takes priority over a timeout on the same edge.
                    if (bus_ack) begin
                        state     <= StResp;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= bus_we ? 32'd0 : bus_rdata;
                    end else if (cnt == CntLast) begin
                        state     <= StResp;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    rsp_valid  <= 1'b0;
                    core_ready <= 1'b1;
                end
                default: begin
                    state <= StInit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Scoreboard bench for lsu_bus_initiator: a small memory model answers the bus, expected
// responses are queued at request time and compared when rsp_valid pulses.
module tb_lsu_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic        core_ready;
    logic        core_write;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_bus_initiator #(
        .ADDR_LIMIT    (1024),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_valid(core_valid),
        .core_ready(core_ready),
        .core_write(core_write),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] mem[256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(mon_e[32]));
                check("rsp_rdata", rsp_rdata, mon_e[31:0]);
            end
        end
    end

    task automatic wait_ready();
        int waited = 0;
        while (core_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(waited < 50), 32'd1);
    endtask

    // ack_at = 0 means the memory never acknowledges.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int ack_at, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_req);
        int req_cycles = 0;
        int waited = 0;
        wait_ready();
        core_valid = 1'b1;
        core_write = w;
        core_addr  = a;
        core_wdata = d;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        core_valid = 1'b0;
        while (bus_req === 1'b1 && req_cycles < 100) begin
            req_cycles++;
            check("bus_addr", bus_addr, a);
            check("bus_we", 32'(bus_we), 32'(w));
            check("bus_wdata", bus_wdata, d);
            if (req_cycles == ack_at) begin
                bus_ack = 1'b1;
                if (bus_we) mem[bus_addr[9:2]] = bus_wdata;
                else bus_rdata = mem[bus_addr[9:2]];
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom();
        end
        check("req_cycles", 32'(req_cycles), 32'(exp_req));
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        check("rsp_seen", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        core_valid = 1'b0;
        core_write = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        foreach (mem[i]) mem[i] = '0;
        mem[4] = 32'hDEAD_BEEF;
        mem[9] = 32'hA5A5_0F0F;

        repeat (2) @(negedge clk);
        check("rst_core_ready", 32'(core_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("ready_first_edge", 32'(core_ready), 32'd1);
        @(negedge clk);
        check("ready_idle", 32'(core_ready), 32'd1);
        check("idle_bus_req", 32'(bus_req), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        txn(1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 3);
        repeat (2) @(negedge clk);
        check("rsp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        txn(1'b1, 32'h3FC, 32'h1234_5678, 1, 32'h0, 1'b0, 1);
        txn(1'b0, 32'h3FC, 32'h0, 2, 32'h1234_5678, 1'b0, 2);
        txn(1'b0, 32'h6, 32'h0, 0, 32'h0, 1'b1, 0);
        txn(1'b0, 32'h400, 32'h0, 0, 32'h0, 1'b1, 0);
        txn(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 1'b1, 0);
        txn(1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b1, 4);
        txn(1'b0, 32'h24, 32'h0, 4, 32'hA5A5_0F0F, 1'b0, 4);

        // Reset in the middle of a bus cycle: no response may follow.
        wait_ready();
        core_valid = 1'b1;
        core_write = 1'b0;
        core_addr  = 32'h10;
        @(negedge clk);
        core_valid = 1'b0;
        @(negedge clk);
        check("midrst_req_before", 32'(bus_req), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_req_async", 32'(bus_req), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_rsp", 32'(exp_q.size()), 32'd0);

        txn(1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_initiator.md
Name: lsu_bus_initiator

Overview:
- Load/store initiator between the core's lw/sw execute stage and a word-addressed data memory that has a variable-latency req/ack port.
- Accepts one request at a time and checks alignment and range.
- Drives the memory bus, waits for the ack with a timeout, and returns load data or an error as a one-cycle response pulse.
- The core stalls while core_ready is low.

Parameters:
ADDR_LIMIT, 1024, byte-address bound; addresses >= ADDR_LIMIT are rejected (1 KB data memory).
TIMEOUT_CYCLES, 255, maximum cycles bus_req stays high without bus_ack before the transaction aborts; legal range 1..65535.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
core_valid  input  1  core presents a request.
core_ready  output  1  initiator can accept a request.
core_write  input  1  1 = sw, 0 = lw.
core_addr  input  32  byte address (ALU result).
core_wdata  input  32  store data (rt value).
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  1  misaligned, out-of-range or timeout.
bus_req  output  1  memory request.
bus_we  output  1  write enable toward memory.
bus_addr  output  32  byte address, low two bits always 0.
bus_wdata  output  32  store data.
bus_ack  input  1  memory completion, sampled on clk.
bus_rdata  input  32  read data, valid when bus_ack = 1.

Behaviour:
- All outputs are registered.
- While rst = 0:
  - state = INIT;
  - core_ready, rsp_valid, rsp_err, bus_req and bus_we = 0;
  - rsp_rdata, bus_addr and bus_wdata = 0;
  - timeout counter = 0.
- Reset mid-transaction drops bus_req immediately (asynchronously), discards the transaction and issues no response.
- FSM states: INIT, IDLE, BUS, RESP.
  - INIT -> IDLE on the first edge after reset release.
  - core_ready = 1 only in IDLE.
- Acceptance happens when core_valid & core_ready at an edge. Capture write, addr and wdata.
  - If core_addr[1:0] != 0 or core_addr >= ADDR_LIMIT: go to RESP with rsp_err = 1 and rsp_rdata = 0. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS state:
  - bus_req = 1.
  - bus_we, bus_addr and bus_wdata come from the captured values and stay stable until the transaction ends.
  - The counter increments each cycle in BUS.
- bus_ack = 1 at an edge in BUS:
  - bus_req drops at that edge and the FSM goes to RESP with rsp_err = 0.
  - rsp_rdata = bus_rdata for loads, 0 for stores.
- No ack by the edge at which the counter reaches TIMEOUT_CYCLES: drop bus_req, go to RESP with rsp_err = 1, rsp_rdata = 0.
- Ack arriving on the same edge as the timeout: the ack wins and the transaction completes normally.
- RESP state: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err hold until the next response.
- bus_ack in INIT, IDLE or RESP is ignored, with no state change.
- core_valid outside IDLE is ignored. The core must hold its request until accepted.
- Latency: accept at edge k, bus_req high from k+1; ack sampled at edge k+n (n >= 1) gives rsp_valid during cycle k+n+1. Error responses appear at k+1.
- Throughput: at most one transaction per 3 cycles. There is no pipelining or outstanding-request queue.
- Address arithmetic: unsigned 32-bit compare against ADDR_LIMIT. No wrap-around.
- Counter width: ceil(log2(TIMEOUT_CYCLES+1)) bits; it clears on every entry to BUS.

Test Plan:
- Reset, release, then idle 2 cycles -> core_ready = 1 from the first edge after release. All other outputs 0.
- lw at addr 0x0000_0010; memory acks after 3 cycles with rdata 0xDEAD_BEEF -> bus_req high for 3 cycles with bus_addr = 0x10 and bus_we = 0. One rsp_valid pulse with rsp_rdata = 0xDEAD_BEEF and rsp_err = 0.
- sw of 0x1234_5678 to 0x0000_03FC with a 1-cycle ack -> bus_we = 1, bus_wdata = 0x1234_5678, rsp_rdata = 0, rsp_err = 0. Then lw 0x3FC returns 0x1234_5678.
- lw at 0x0000_0006, then lw at 0x0000_0400 -> each gives rsp_err = 1 one cycle after accept, with bus_req never asserted.
- Memory never acks, TIMEOUT_CYCLES = 4 -> bus_req high exactly 4 cycles, then rsp_valid with rsp_err = 1. A second run with ack on cycle 4 gives rsp_err = 0.
- rst asserted while bus_req = 1 -> bus_req low before the next edge and no rsp_valid. After release, a fresh lw completes normally.
